tick_period_monitor: RTL
========================

// Module: tick_period_monitor
// PURPOSE
//  Receive-side counterpart to the board's tick/clock-divider pulse trains.
//  Synchronises an incoming pulse stream and measures rising-edge-to-rising-edge
//  period in CLK_in cycles. Flags each result as in/out of tolerance against an
//  expected period, asserts lock after consecutive good periods, and detects loss
//  of ticks (timeout). Used to check divider outputs, e.g. the jackpot tick, on the ZYBO.
// PARAMETERS
//  W           32         width of period counter and period_out
//  MAX_PERIOD  250000000  cycles with no edge before timeout (2 s @ 125 MHz)
//  EXPECTED    10000001   nominal period in cycles
//  TOL         0          allowed |period - EXPECTED| for in_tol
//  LOCK_COUNT  3          consecutive in-tol periods required for locked (>=1)
// PORTS
//  CLK_in        in   1  system clock, all logic on posedge
//  reset         in   1  synchronous, active-high reset
//  pulse_in      in   1  monitored pulse stream, may be asynchronous to CLK_in
//  period_out    out  W  last measured period in cycles; held between updates
//  period_valid  out  1  one-cycle strobe: period_out/in_tol updated this cycle
//  in_tol        out  1  last period within EXPECTED +/- TOL
//  locked        out  1  >= LOCK_COUNT consecutive in-tol periods, no timeout since
//  timeout       out  1  sticky: no edge for MAX_PERIOD cycles; clears on next edge
// BEHAVIOUR
//  - Reset: period_out=0, period_valid=0, in_tol=0, locked=0, timeout=0,
//    cnt=0, lock_cnt=0, sync flops=0, state=IDLE. Reset overrides all else.
//  - Input path: 2-flop synchroniser s1->s2, plus history flop s3.
//    edge = s2 & ~s3. Edge is seen 2-3 cycles after pulse_in rises.
//    Width of pulse_in is irrelevant; only rising edges count.
//  - FSM states IDLE, MEASURE, TIMEOUT:
//    IDLE:    edge -> MEASURE, cnt<=0, no strobe (first edge only arms).
//    MEASURE: no edge -> cnt<=cnt+1. When cnt+1 == MAX_PERIOD with no edge
//             -> TIMEOUT, timeout<=1, locked<=0, lock_cnt<=0.
//             edge -> period_out<=cnt+1, period_valid<=1 for 1 cycle, cnt<=0,
//             stay MEASURE. Edges P cycles apart give period_out=P.
//    TIMEOUT: cnt frozen. Edge -> MEASURE, timeout<=0, cnt<=0, no strobe
//             (re-arm; the gap before this edge is not reported).
//  - Edge and timeout threshold in the same cycle: edge wins; the period is
//    reported and no timeout occurs.
//  - in_tol is computed from the new period and registered with period_valid.
//    Compare (P>=EXPECTED-TOL && P<=EXPECTED+TOL). Use W+1-bit arithmetic so
//    there is no wrap when EXPECTED<TOL.
//  - lock_cnt updates on each strobe: in-tol -> saturating increment up to
//    LOCK_COUNT; out-of-tol -> 0. locked = (lock_cnt==LOCK_COUNT), registered
//    in the strobe cycle.
//  - cnt never wraps: MAX_PERIOD <= 2^W-1 is required. The bench asserts this.
//  - Reset in the middle of a measurement discards it. The first edge after
//    reset only arms the monitor.
// TESTING (override: EXPECTED=10, TOL=1, MAX_PERIOD=50, LOCK_COUNT=3)
//  1 Reset, then 1-cycle pulses every 10 cycles -> 1st edge gives no strobe;
//    each later edge gives period_valid pulse, period_out=10, in_tol=1;
//    locked=1 on the 3rd strobe.
//  2 Locked, then one gap of 13 cycles -> period_out=13, in_tol=0, locked=0;
//    three more 10s -> locked=1 again.
//  3 Periods 9 and 11 -> in_tol=1. Periods 8 and 12 -> in_tol=0.
//  4 Stop pulses -> timeout=1 exactly 50 cycles after the last edge counted
//    (cnt+1==50); locked=0. Next edge -> timeout=0, no strobe. Following
//    edge 10 later -> period_out=10.
//  5 Edge arriving on the exact timeout cycle (period 50) -> strobe,
//    period_out=50, timeout stays 0.
//  6 Assert reset mid-period and hold pulse_in high 20 cycles -> all outputs 0.
//    One rising edge only after reset releases, and the first strobe occurs
//    only at the second edge.

Source files
------------

// File: rtl/tick_period_monitor.sv
// Measures rising-edge-to-rising-edge period of an asynchronous pulse stream in
// CLK_in cycles, with tolerance flag, lock detection and loss-of-tick timeout.
module tick_period_monitor #(
  parameter int unsigned W          = 32,
  parameter int unsigned MAX_PERIOD = 250000000,
  parameter int unsigned EXPECTED   = 10000001,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_COUNT = 3
) (
  input  logic         CLK_in,
  input  logic         reset,
  input  logic         pulse_in,
  output logic [W-1:0] period_out,
  output logic         period_valid,
  output logic         in_tol,
  output logic         locked,
  output logic         timeout
);

  localparam int unsigned LCW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [W:0]     LP_MAX  = (W+1)'(MAX_PERIOD);
  localparam logic [W:0]     LP_EXP  = (W+1)'(EXPECTED);
  localparam logic [W:0]     LP_TOL  = (W+1)'(TOL);
  localparam logic [LCW-1:0] LP_LOCK = LCW'(LOCK_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_TIMEOUT} state_t;

  state_t         r_state;
  logic [W-1:0]   r_cnt;
  logic [LCW-1:0] r_lock_cnt;
  logic           r_s1, r_s2, r_s3;

  logic           w_edge;
  logic [W:0]     w_period;
  logic           w_in_tol;
  logic [LCW-1:0] w_lock_nxt;

  always_ff @(posedge CLK_in) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pulse_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge   = r_s2 & ~r_s3;
  assign w_period = {1'b0, r_cnt} + (W+1)'(1);

  // Lower bound rearranged as P+TOL >= EXPECTED so a small EXPECTED cannot wrap.
  assign w_in_tol = ((w_period + LP_TOL) >= LP_EXP) &&
                    (w_period <= (LP_EXP + LP_TOL));

  assign w_lock_nxt = !w_in_tol                ? '0 :
                      (r_lock_cnt == LP_LOCK)  ? r_lock_cnt :
                                                 r_lock_cnt + LCW'(1);

  always_ff @(posedge CLK_in) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_lock_cnt   <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      in_tol       <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_state <= S_MEASURE;
            r_cnt   <= '0;
          end
        end
        S_MEASURE: begin
          // An edge on the threshold cycle is reported, never timed out.
          if (w_edge) begin
            period_out   <= w_period[W-1:0];
            period_valid <= 1'b1;
            in_tol       <= w_in_tol;
            r_lock_cnt   <= w_lock_nxt;
            locked       <= (w_lock_nxt == LP_LOCK);
            r_cnt        <= '0;
          end else if (w_period == LP_MAX) begin
            r_state    <= S_TIMEOUT;
            timeout    <= 1'b1;
            locked     <= 1'b0;
            r_lock_cnt <= '0;
          end else begin
            r_cnt <= w_period[W-1:0];
          end
        end
        S_TIMEOUT: begin
          if (w_edge) begin
            r_state <= S_MEASURE;
            timeout <= 1'b0;
            r_cnt   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
